// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: control inputs from hazard/decode/commit, fetch outputs.
// master drives the control inputs, slave is the sequencer itself.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              Stall;
    logic              RedirectValid;
    logic [ADDR_W-1:0] RedirectAddr;
    logic              BranchValid;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Call;
    logic              Ret;
    logic [ADDR_W-1:0] PCResult;
    logic [ADDR_W-1:0] PCPlus;
    logic              PCValid;
    logic              MisalignFault;
    logic              RasEmpty;

    modport master (
        output Stall, RedirectValid, RedirectAddr, BranchValid, BranchTarget, Call, Ret,
        input  PCResult, PCPlus, PCValid, MisalignFault, RasEmpty
    );

    modport slave (
        input  Stall, RedirectValid, RedirectAddr, BranchValid, BranchTarget, Call, Ret,
        output PCResult, PCPlus, PCValid, MisalignFault, RasEmpty
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with redirect/stall/branch/return selection.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN; without it
// Call/Ret are ignored and RasEmpty is tied high.
module pc_sequencer #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input logic           Clk,
    input logic           Reset,
    pc_sequencer_if.slave bus
);
    // Low bits that must be zero in any loaded target.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus;
    logic              valid_q;
    logic              fault_q, fault_d;
    logic              advance;
    logic              ras_empty;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic [ADDR_W-1:0] tgt;

    assign pc_plus = pc_q + ADDR_W'(INSTR_BYTES);
    // Stack and sequential flow only move when neither flushed nor stalled.
    assign advance = !bus.RedirectValid && !bus.Stall;

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ras_push;

    assign ras_empty = (cnt_q == '0);
    assign ras_top   = ras_mem[top_q];
    assign ras_push  = advance && bus.Call;
    // A taken branch overrides a return, so the stack is left alone.
    assign ras_pop   = advance && bus.Ret && !ras_empty && !bus.BranchValid;

    // Stack pointer/occupancy; push when full wraps onto the oldest slot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            top_q <= '0;
            cnt_q <= '0;
        end else if (ras_push && !ras_pop) begin
            top_q <= top_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
        end else if (ras_pop && !ras_push) begin
            top_q <= top_q - 1'b1;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Stack storage; simultaneous call+return replaces the top entry in place.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (ras_push && ras_pop) ras_mem[top_q] <= pc_plus;
            else if (ras_push)       ras_mem[top_q + 1'b1] <= pc_plus;
        end
    end
`else
    logic unused_ras_ins;
    assign unused_ras_ins = bus.Call ^ bus.Ret;
    assign ras_empty      = 1'b1;
    assign ras_pop        = 1'b0;
    assign ras_top        = '0;
`endif

    // Next-PC selection: redirect > stall > branch > return > sequential.
    always_comb begin
        pc_d    = pc_q;
        fault_d = 1'b0;
        tgt     = '0;
        if (bus.RedirectValid || (advance && (bus.BranchValid || ras_pop))) begin
            if (bus.RedirectValid)    tgt = bus.RedirectAddr;
            else if (bus.BranchValid) tgt = bus.BranchTarget;
            else                      tgt = ras_top;
            pc_d    = tgt & ~ALIGN_MASK;
            fault_d = |(tgt & ALIGN_MASK);
        end else if (advance) begin
            pc_d = pc_plus;
        end
    end

    // PC, valid and fault registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_VEC;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
            fault_q <= fault_d;
        end
    end

    assign bus.PCResult      = pc_q;
    assign bus.PCPlus        = pc_plus;
    assign bus.PCValid       = valid_q;
    assign bus.MisalignFault = fault_q;
    assign bus.RasEmpty      = ras_empty;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random stimulus
// compared against a queue-based reference model. Return-stack scenarios run
// only when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;
    localparam logic [31:0] RVEC = 32'h100;
    localparam int unsigned DEPTH = 4;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W(32),
        .RESET_VEC(RVEC),
        .INSTR_BYTES(4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the stated rules, then check all outputs.
    task automatic step(input bit rst, input bit stall, input bit rv, input logic [31:0] ra,
                        input bit bv, input logic [31:0] bt, input bit call, input bit ret);
        logic [31:0] plus;
        logic [31:0] t;
        bit          has_ras;
        bit          pop;
        Reset             = rst;
        bus.Stall         = stall;
        bus.RedirectValid = rv;
        bus.RedirectAddr  = ra;
        bus.BranchValid   = bv;
        bus.BranchTarget  = bt;
        bus.Call          = call;
        bus.Ret           = ret;
        plus = m_pc + 32'd4;
        if (rst) begin
            m_pc    = RVEC;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_ras.delete();
        end else begin
            m_valid = 1'b1;
            if (rv) begin
                m_pc    = {ra[31:2], 2'b00};
                m_fault = (ra[1:0] != 2'b00);
            end else if (stall) begin
                m_fault = 1'b0;
            end else begin
`ifdef PC_SEQ_RAS_EN
                has_ras = (m_ras.size() > 0);
`else
                has_ras = 1'b0;
`endif
                pop = ret && has_ras && !bv;
                if (bv || pop) begin
                    t       = bv ? bt : m_ras[m_ras.size() - 1];
                    m_pc    = {t[31:2], 2'b00};
                    m_fault = (t[1:0] != 2'b00);
                end else begin
                    m_pc    = plus;
                    m_fault = 1'b0;
                end
`ifdef PC_SEQ_RAS_EN
                if (pop) void'(m_ras.pop_back());
                if (call) begin
                    m_ras.push_back(plus);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
`endif
            end
        end
        @(posedge Clk);
        #1;
        chk("PCResult", bus.PCResult, m_pc);
        chk("PCPlus", bus.PCPlus, m_pc + 32'd4);
        chk("PCValid", {31'b0, bus.PCValid}, {31'b0, m_valid});
        chk("MisalignFault", {31'b0, bus.MisalignFault}, {31'b0, m_fault});
        chk("RasEmpty", {31'b0, bus.RasEmpty}, {31'b0, (m_ras.size() == 0)});
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        logic [31:0] pushed[5];

        // 1: reset then three free-running cycles.
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
        chk("t1_pc_reset", bus.PCResult, 32'h100);
        chk("t1_valid_reset", {31'b0, bus.PCValid}, 32'd0);
        chk("t1_rasempty_reset", {31'b0, bus.RasEmpty}, 32'd1);
        idle();
        chk("t1_valid_after", {31'b0, bus.PCValid}, 32'd1);
        chk("t1_pc1", bus.PCResult, 32'h104);
        idle();
        idle();
        chk("t1_pc3", bus.PCResult, 32'h10C);

        // 2: stall holds even with a pending branch; branch lands once stall drops.
        step(0, 0, 0, 32'h0, 1, 32'h200, 0, 0);
        step(0, 1, 0, 32'h0, 0, 32'h0, 1, 1);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 32'h40, 0, 0);
        chk("t2_hold", bus.PCResult, 32'h200);
        step(0, 0, 0, 32'h0, 1, 32'h40, 0, 0);
        chk("t2_branch", bus.PCResult, 32'h40);

        // 3: redirect beats stall and branch.
        step(0, 1, 1, 32'h800, 1, 32'h40, 0, 0);
        chk("t3_redirect", bus.PCResult, 32'h800);
        chk("t3_fault", {31'b0, bus.MisalignFault}, 32'd0);

        // 4: misaligned branch faults for one cycle; top-of-space wrap.
        step(0, 0, 0, 32'h0, 1, 32'h1002, 0, 0);
        chk("t4_aligned", bus.PCResult, 32'h1000);
        chk("t4_fault", {31'b0, bus.MisalignFault}, 32'd1);
        idle();
        chk("t4_fault_clear", {31'b0, bus.MisalignFault}, 32'd0);
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0);
        idle();
        chk("t4_wrap", bus.PCResult, 32'h0);
        chk("t4_wrap_fault", {31'b0, bus.MisalignFault}, 32'd0);

        // Reset during stall+redirect discards the pending inputs.
        step(1, 1, 1, 32'h4444, 1, 32'h88, 1, 0);
        chk("rst_mid", bus.PCResult, 32'h100);

`ifdef PC_SEQ_RAS_EN
        // 5: nested calls then returns.
        step(0, 0, 1, 32'h10, 0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 1, 32'h50, 1, 0);
        chk("t5_nonempty", {31'b0, bus.RasEmpty}, 32'd0);
        step(0, 0, 0, 32'h0, 1, 32'h90, 1, 0);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("t5_ret1", bus.PCResult, 32'h54);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("t5_ret2", bus.PCResult, 32'h14);
        chk("t5_empty", {31'b0, bus.RasEmpty}, 32'd1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("t5_ret3_seq", bus.PCResult, 32'h18);

        // 6: overflow keeps the newest four return addresses.
        for (int i = 0; i < 5; i++) begin
            pushed[i] = bus.PCResult + 32'd4;
            step(0, 0, 0, 32'h0, 1, 32'h1000 * (i + 1), 1, 0);
        end
        for (int i = 4; i >= 1; i--) begin
            step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
            chk("t6_pop", bus.PCResult, pushed[i]);
        end
        step(0, 0, 0, 32'h0, 0, 32'h0, 0, 1);
        chk("t6_seq", bus.PCResult, pushed[1] + 32'd4);
`endif

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            b = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h0000_FFFC);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), a, ($urandom_range(0, 3) == 0), b,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
